// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer and the detector bench that consumes its stream.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned SER_WIDTH = 8;
    localparam int unsigned CNT_W     = $clog2(SER_WIDTH);
    localparam int unsigned MAX_W     = 64;

    // Bit currently at the output end of the shift register.
    function automatic logic head_bit(input logic [MAX_W-1:0] word,
                                      input int unsigned      width,
                                      input bit               lsb_first);
        logic [MAX_W-1:0] msb_aligned;
        msb_aligned = word >> (width - 1);
        return lsb_first ? word[0] : msb_aligned[0];
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out,
// with a one-word holding register so consecutive words stream without a gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned       CNT_WL   = $clog2(WIDTH);
    localparam logic [CNT_WL-1:0] CNT_LAST = CNT_WL'(WIDTH - 1);

    state_e            state_q;
    logic [CNT_WL-1:0] cnt_q;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  shift_d;
    logic [WIDTH-1:0]  hold_q;
    logic              hold_valid_q;

    logic accept;
    logic shifting;
    logic last_bit;

    // Ready depends only on the hold flag, so there is no path from in_valid back to in_ready.
    assign in_ready = reset_n && !hold_valid_q;
    assign accept   = in_valid && in_ready;
    assign shifting = (state_q == SHIFT);
    assign last_bit = shifting && (cnt_q == CNT_LAST);
    assign shift_d  = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

    assign ser_valid = shifting;
    assign ser_bit   = shifting ? head_bit(MAX_W'(shift_q), WIDTH, LSB_FIRST) : IDLE_LEVEL;
    assign ser_first = shifting && (cnt_q == '0);
    assign ser_last  = last_bit;
    assign busy      = shifting || hold_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q <= in_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        // Held word wins; in_ready is low here so no accept can collide with it.
                        if (hold_valid_q) begin
                            shift_q      <= hold_q;
                            hold_valid_q <= 1'b0;
                        end else if (accept) begin
                            shift_q <= in_data;
                        end else begin
                            shift_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CNT_WL'(1);
                        if (accept) begin
                            hold_q       <= in_data;
                            hold_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance (idle low) and LSB-first instance (idle high).
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data_a = 8'h00;
    logic [7:0] in_data_b = 8'h00;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_a, ser_bit_a, ser_valid_a, ser_first_a, ser_last_a, busy_a;
    logic       in_ready_b, ser_bit_b, ser_valid_b, ser_first_b, ser_last_b, busy_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a),
        .ser_first(ser_first_a), .ser_last(ser_last_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b),
        .ser_first(ser_first_b), .ser_last(ser_last_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_chk(input string tag, input logic b, input logic f, input logic l,
                             input logic rdy);
        chk({tag, ".valid"}, ser_valid_a, 1'b1);
        chk({tag, ".bit"},   ser_bit_a,   b);
        chk({tag, ".first"}, ser_first_a, f);
        chk({tag, ".last"},  ser_last_a,  l);
        chk({tag, ".ready"}, in_ready_a,  rdy);
        chk({tag, ".busy"},  busy_a,      1'b1);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".valid"}, ser_valid_a, 1'b0);
        chk({tag, ".bit"},   ser_bit_a,   1'b0);
        chk({tag, ".first"}, ser_first_a, 1'b0);
        chk({tag, ".last"},  ser_last_a,  1'b0);
        chk({tag, ".busy"},  busy_a,      1'b0);
        chk({tag, ".ready"}, in_ready_a,  1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  w;
        logic [15:0] w2;
        logic [23:0] w3;

        // Reset state on both instances
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst.ready_a", in_ready_a, 1'b0);
        chk("rst.ready_b", in_ready_b, 1'b0);
        chk("rst.valid_a", ser_valid_a, 1'b0);
        chk("rst.bit_a",   ser_bit_a,   1'b0);
        chk("rst.busy_a",  busy_a,      1'b0);
        chk("rst.first_a", ser_first_a, 1'b0);
        chk("rst.last_a",  ser_last_a,  1'b0);
        chk("rst.valid_b", ser_valid_b, 1'b0);
        chk("rst.bit_b",   ser_bit_b,   1'b1);
        chk("rst.busy_b",  busy_b,      1'b0);
        reset_n = 1'b1;
        tick();
        idle_chk("post_rst");

        // Single word 0xB3, MSB first; later in_data changes must not matter
        w = 8'hB3;
        in_data_a = w; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0; in_data_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            shift_chk("t1", w[7-i], i == 0, i == 7, 1'b1);
            tick();
        end
        idle_chk("t1.end");

        // Back-to-back 0xFF then 0x00 through the holding register
        w2 = 16'hFF00;
        in_data_a = 8'hFF; in_valid_a = 1'b1;
        tick();
        in_data_a = 8'h00;
        for (int i = 0; i < 16; i++) begin
            shift_chk("t2", w2[15-i], (i % 8) == 0, (i % 8) == 7, (i == 0) || (i >= 8));
            tick();
            if (i == 0) in_valid_a = 1'b0;
        end
        idle_chk("t2.end");

        // Third word offered while one shifts and one is held
        w3 = 24'hC35A3C;
        in_data_a = 8'hC3; in_valid_a = 1'b1;
        tick();
        in_data_a = 8'h5A;
        for (int i = 0; i < 24; i++) begin
            shift_chk("t4", w3[23-i], (i % 8) == 0, (i % 8) == 7,
                      (i == 0) || (i == 8) || (i >= 16));
            tick();
            if (i == 0) in_data_a = 8'h3C;
            if (i == 8) in_valid_a = 1'b0;
        end
        idle_chk("t4.end");

        // Direct load on the last-bit cycle with the hold register empty
        w2 = 16'h0FF0;
        in_data_a = 8'h0F; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            shift_chk("t6", w2[15-i], (i % 8) == 0, (i % 8) == 7, 1'b1);
            if (i == 7) begin
                in_data_a = 8'hF0; in_valid_a = 1'b1;
            end
            tick();
            if (i == 7) in_valid_a = 1'b0;
        end
        idle_chk("t6.end");

        // Reset during bit 3 of 0xA5 with 0x3C held
        w = 8'hA5;
        in_data_a = w; in_valid_a = 1'b1;
        tick();
        in_data_a = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            shift_chk("t5", w[7-i], i == 0, 1'b0, i == 0);
            if (i < 3) tick();
            if (i == 0) in_valid_a = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("t5.rst_ready", in_ready_a, 1'b0);
        tick();
        reset_n = 1'b1;
        #1;
        idle_chk("t5.after");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5.quiet_valid", ser_valid_a, 1'b0);
            chk("t5.quiet_busy",  busy_a,      1'b0);
        end

        // LSB-first instance, 0x01, idle level high
        w = 8'h01;
        in_data_b = w; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3.valid", ser_valid_b, 1'b1);
            chk("t3.bit",   ser_bit_b,   w[i]);
            chk("t3.first", ser_first_b, i == 0);
            chk("t3.last",  ser_last_b,  i == 7);
            tick();
        end
        chk("t3.end_valid", ser_valid_b, 1'b0);
        chk("t3.end_bit",   ser_bit_b,   1'b1);
        chk("t3.end_busy",  busy_b,      1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
